sumador_segmentado: RTL and testbench

Parametrised pipelined adder/subtractor, the next generation of the team's ripple-carry adder chain.
- The WIDTH-bit operation is split into NSEG = WIDTH/SEG_W segments; one segment is resolved per pipeline stage, with the carry registered between stages.
- Adds subtract mode, signed overflow, a valid/ready handshake with backpressure, and one result per cycle.
- Used as the core arithmetic unit wherever 64-bit-class sums must meet timing.

---
 rtl/sumador_segmentado.sv | 123 ++++++++++++
 tb/tb_sumador_segmentado.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/sumador_segmentado.sv
// Pipelined adder/subtractor: one SEG_W-bit segment is resolved per stage, with the carry
// registered between stages. A single global advance enable gives valid/ready backpressure.
module sumador_segmentado #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned SEG_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int unsigned NSEG = WIDTH / SEG_W;

  if ((WIDTH % SEG_W) != 0 || NSEG < 1) begin : gen_param_check
    $error("sumador_segmentado: WIDTH must be a nonzero multiple of SEG_W");
  end

  logic adv;

  for (genvar k = 0; k < NSEG; k++) begin : gen_stage
    localparam int unsigned InW  = WIDTH - k * SEG_W;
    localparam int unsigned ResW = (k + 1) * SEG_W;

    logic            v_in, c_in, s_in, load;
    logic [InW-1:0]  a_in, b_in;
    logic [SEG_W:0]  seg;
    logic [ResW-1:0] res_new, res_d, res_q;
    logic            vld_d, vld_q, cy_d, cy_q, sub_d, sub_q;

    assign seg  = {1'b0, a_in[SEG_W-1:0]} + {1'b0, b_in[SEG_W-1:0]} + {{SEG_W{1'b0}}, c_in};
    // Data registers only load on a valid transfer, so bubble-time inputs never reach results.
    assign load = adv & v_in;

    if (k == 0) begin : gen_src
      assign v_in    = in_valid;
      assign a_in    = a;
      assign b_in    = sub ? ~b : b;
      assign c_in    = sub ? ~cin : cin;
      assign s_in    = sub;
      assign res_new = seg[SEG_W-1:0];
    end else begin : gen_src
      assign v_in    = gen_stage[k-1].vld_q;
      assign a_in    = gen_stage[k-1].gen_ops.opa_q;
      assign b_in    = gen_stage[k-1].gen_ops.opb_q;
      assign c_in    = gen_stage[k-1].cy_q;
      assign s_in    = gen_stage[k-1].sub_q;
      assign res_new = {seg[SEG_W-1:0], gen_stage[k-1].res_q};
    end

    always_comb begin
      vld_d = adv ? v_in : vld_q;
      cy_d  = load ? seg[SEG_W] : cy_q;
      sub_d = load ? s_in : sub_q;
      res_d = load ? res_new : res_q;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld_q <= 1'b0;
        cy_q  <= 1'b0;
        sub_q <= 1'b0;
        res_q <= '0;
      end else begin
        vld_q <= vld_d;
        cy_q  <= cy_d;
        sub_q <= sub_d;
        res_q <= res_d;
      end
    end

    if (k < NSEG - 1) begin : gen_ops
      // Operand segments not yet consumed travel with the operation.
      logic [InW-SEG_W-1:0] opa_d, opa_q, opb_d, opb_q;

      always_comb begin
        opa_d = load ? a_in[InW-1:SEG_W] : opa_q;
        opb_d = load ? b_in[InW-1:SEG_W] : opb_q;
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          opa_q <= '0;
          opb_q <= '0;
        end else begin
          opa_q <= opa_d;
          opb_q <= opb_d;
        end
      end
    end else begin : gen_ovf
      logic ovf_d, ovf_q;

      // Carry into the MSB recovered as a^b^s at that bit, XORed with the carry out.
      always_comb begin
        ovf_d = load ? (a_in[SEG_W-1] ^ b_in[SEG_W-1] ^ seg[SEG_W-1] ^ seg[SEG_W]) : ovf_q;
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ovf_q <= 1'b0;
        end else begin
          ovf_q <= ovf_d;
        end
      end
    end
  end

  assign adv       = ~gen_stage[NSEG-1].vld_q | out_ready;
  assign in_ready  = adv & ~rst;
  assign out_valid = gen_stage[NSEG-1].vld_q;
  assign sum       = gen_stage[NSEG-1].res_q;
  assign cout      = gen_stage[NSEG-1].cy_q ^ gen_stage[NSEG-1].sub_q;
  assign ovf       = gen_stage[NSEG-1].gen_ovf.ovf_q;

endmodule

// File: tb/tb_sumador_segmentado.sv
// Directed and randomised bench for sumador_segmentado at SEG_W = 16, 8 and 64 (WIDTH = 64).
module tb_sumador_segmentado;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        cin = 1'b0;
  logic        sub = 1'b0;
  logic        out_ready = 1'b1;
  logic [63:0] a = '0;
  logic [63:0] b = '0;

  logic        rdy16, v16, co16, of16, rdy8, v8, co8, of8, rdy64, v64, co64, of64;
  logic [63:0] s16, s8, s64;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [63:0] s;
    logic        c;
    logic        o;
  } res_t;

  res_t q[$];

  always #5 clk = ~clk;

  sumador_segmentado #(.WIDTH(64), .SEG_W(16)) u16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy16), .a(a), .b(b), .cin(cin),
    .sub(sub), .out_valid(v16), .out_ready(out_ready), .sum(s16), .cout(co16), .ovf(of16)
  );

  sumador_segmentado #(.WIDTH(64), .SEG_W(8)) u8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy8), .a(a), .b(b), .cin(cin),
    .sub(sub), .out_valid(v8), .out_ready(out_ready), .sum(s8), .cout(co8), .ovf(of8)
  );

  sumador_segmentado #(.WIDTH(64), .SEG_W(64)) u64 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy64), .a(a), .b(b), .cin(cin),
    .sub(sub), .out_valid(v64), .out_ready(out_ready), .sum(s64), .cout(co64), .ovf(of64)
  );

  task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Reference: plain 65-bit arithmetic, borrow taken from the sign of the wide difference.
  function automatic res_t model(input logic [63:0] x, input logic [63:0] y,
                                 input logic ci, input logic sb);
    logic [64:0] f;
    res_t        r;
    if (!sb) begin
      f   = {1'b0, x} + {1'b0, y} + {64'd0, ci};
      r.o = (x[63] == y[63]) && (f[63] != x[63]);
    end else begin
      f   = {1'b0, x} - {1'b0, y} - {64'd0, ci};
      r.o = (x[63] != y[63]) && (f[63] != x[63]);
    end
    r.s = f[63:0];
    r.c = f[64];
    return r;
  endfunction

  // One isolated op; each instance must present it exactly at its own latency.
  task automatic run_op(input string tag, input logic [63:0] x, input logic [63:0] y,
                        input logic ci, input logic sb, input logic [63:0] es,
                        input logic ec, input logic eo);
    @(negedge clk);
    a = x; b = y; cin = ci; sub = sb; in_valid = 1'b1; out_ready = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      if (n == 1) begin
        chk1({tag, " n1 valid"}, v64, 1'b1);
        chk64({tag, " n1 sum"}, s64, es);
        chk1({tag, " n1 cout"}, co64, ec);
        chk1({tag, " n1 ovf"}, of64, eo);
      end
      if (n == 3) chk1({tag, " n16 early"}, v16, 1'b0);
      if (n == 4) begin
        chk1({tag, " n4 valid"}, v16, 1'b1);
        chk64({tag, " n4 sum"}, s16, es);
        chk1({tag, " n4 cout"}, co16, ec);
        chk1({tag, " n4 ovf"}, of16, eo);
      end
      if (n == 5) chk1({tag, " n4 one cycle"}, v16, 1'b0);
      if (n == 8) begin
        chk1({tag, " n8 valid"}, v8, 1'b1);
        chk64({tag, " n8 sum"}, s8, es);
        chk1({tag, " n8 cout"}, co8, ec);
        chk1({tag, " n8 ovf"}, of8, eo);
      end
    end
  endtask

  initial begin
    res_t        e;
    logic        held;
    logic [63:0] hs;
    logic        hc, ho;

    // Reset state
    #2 rst = 1'b1;
    #1;
    chk1("rst in_ready", rdy16, 1'b0);
    chk1("rst out_valid", v16, 1'b0);
    chk64("rst sum", s16, 64'd0);
    chk1("rst cout", co16, 1'b0);
    chk1("rst ovf", of16, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk1("post-rst in_ready", rdy16, 1'b1);

    // Directed vectors
    run_op("t1 add wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0);
    run_op("t2 sub borrow", 64'd0, 64'd1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
    run_op("t2 sub bin", 64'd5, 64'd3, 1'b1, 1'b1, 64'd1, 1'b0, 1'b0);
    run_op("t3 add ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0,
           64'h8000_0000_0000_0000, 1'b0, 1'b1);
    run_op("t3 sub ovf", 64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1,
           64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1);

    // Back-to-back stream, no stalls: results on consecutive cycles, 4 cycles after entry
    out_ready = 1'b1;
    for (int c = 0; c < 28; c++) begin
      @(negedge clk);
      chk1("t4 valid timing", v16, (c >= 4 && c < 24));
      if (v16) begin
        chk1("t4 queue nonempty", q.size() != 0, 1'b1);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk64("t4 sum", s16, e.s);
          chk1("t4 cout", co16, e.c);
          chk1("t4 ovf", of16, e.o);
        end
      end
      in_valid = (c < 20);
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      cin = 1'($urandom_range(0, 1));
      sub = 1'($urandom_range(0, 1));
      if (in_valid) q.push_back(model(a, b, cin, sub));
    end
    chk1("t4 all retired", q.size() == 0, 1'b1);
    q.delete();

    // Random backpressure
    held = 1'b0;
    hs = '0; hc = 1'b0; ho = 1'b0;
    for (int c = 0; c < 260; c++) begin
      @(negedge clk);
      if (held) begin
        chk1("t5 hold valid", v16, 1'b1);
        chk64("t5 hold sum", s16, hs);
        chk1("t5 hold cout", co16, hc);
        chk1("t5 hold ovf", of16, ho);
      end
      out_ready = (c < 200) ? 1'($urandom_range(0, 1)) : 1'b1;
      in_valid = (c < 150) && ($urandom_range(0, 9) < 7);
      a = {$urandom, $urandom};
      b = (c % 17 == 0) ? ~a : {$urandom, $urandom};
      cin = 1'($urandom_range(0, 1));
      sub = 1'($urandom_range(0, 1));
      #1;
      chk1("t5 in_ready", rdy16, ~v16 | out_ready);
      if (v16 && out_ready) begin
        chk1("t5 queue nonempty", q.size() != 0, 1'b1);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk64("t5 sum", s16, e.s);
          chk1("t5 cout", co16, e.c);
          chk1("t5 ovf", of16, e.o);
        end
      end
      held = v16 && !out_ready;
      hs = s16; hc = co16; ho = of16;
      if (in_valid && rdy16) q.push_back(model(a, b, cin, sub));
    end
    chk1("t5 all retired", q.size() == 0, 1'b1);
    q.delete();

    // Reset with operations in flight
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      in_valid = 1'b1;
      a = 64'(c + 10);
      b = 64'd1;
      cin = 1'b0;
      sub = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk1("t6 pre-rst valid", v16, 1'b1);
    chk64("t6 pre-rst sum", s16, 64'd11);
    rst = 1'b1;
    #1;
    chk1("t6 rst valid", v16, 1'b0);
    chk64("t6 rst sum", s16, 64'd0);
    chk1("t6 rst cout", co16, 1'b0);
    chk1("t6 rst ovf", of16, 1'b0);
    chk1("t6 rst in_ready", rdy16, 1'b0);
    chk1("t6 rst valid8", v8, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk1("t6 no stale16", v16, 1'b0);
      chk1("t6 no stale8", v8, 1'b0);
      chk1("t6 no stale64", v64, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
